cla_multiword_sequencer: RTL and testbench
==========================================

Name: cla_multiword_sequencer

Overview:
Sequencer that performs wide add/subtract operations (N*WORDS bits) on a single N-bit cla_adder. It processes one N-bit chunk per clock, least significant chunk first, and registers the carry between chunks. It exposes a valid/ready request port and a valid/ready result port, so a narrow CLA can serve wide datapaths in the adder lab designs.

Parameters:
N, 8, chunk width in bits; equals the width of the instantiated cla_adder (N >= 1).
WORDS, 4, number of chunks; total operand width W = N*WORDS (WORDS >= 1).

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  request present.
in_ready  output  1  sequencer can accept a request.
a  input  N*WORDS  operand A.
b  input  N*WORDS  operand B.
c_in  input  1  carry-in (add mode only).
sub  input  1  1 = compute a - b; c_in is ignored.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
sum  output  N*WORDS  result.
c_out  output  1  final carry-out. In sub mode: 1 = no borrow.
ovf  output  1  two's-complement signed overflow of the W-bit result.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; chunk index = 0; carry register = 0.
  - sum = 0, c_out = 0, ovf = 0, out_valid = 0, in_ready = 1 in the cycle after reset is sampled.
  - Reset has priority over every other input.
- States: IDLE, RUN, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
- IDLE:
  - When in_valid is high on a clock edge, capture a and b_eff, where b_eff = sub ? ~b : b.
  - Set carry = sub ? 1 : c_in; index = 0; store the sub flag; go to RUN.
- RUN (one chunk per cycle):
  - The cla_adder inputs are a_reg chunk[idx], b_eff chunk[idx], and the carry register.
  - On each edge: write s into sum chunk[idx]; carry <= cla c_out; idx <= idx + 1.
  - When idx == WORDS-1: latch c_out from the final cla c_out, compute ovf, and go to DONE.
  - ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), evaluated on the final chunk.
- DONE:
  - Hold sum, c_out and ovf stable while out_ready is low.
  - On out_valid && out_ready, go to IDLE.
  - sum, c_out and ovf keep their values in IDLE until the next DONE.
- Latency: accept edge at cycle 0; out_valid is asserted after edge WORDS (WORDS cycles in RUN).
  - Minimum issue interval is WORDS+2 cycles; there is no accept in the same cycle as a result handshake.
- in_valid while in RUN or DONE: ignored. Inputs are not sampled and no request is queued.
- a, b, c_in and sub may change freely after the accept edge; only the captured copies are used.
- Reset mid-RUN or mid-DONE: the operation is discarded and no out_valid is produced for it.
- WORDS = 1: RUN lasts exactly one cycle; the index register has width max(1, $clog2(WORDS)).
- Wrap-around: overflow past W bits is reported only through c_out and ovf; sum is modulo 2^W.
- All internal arithmetic goes through the cla_adder instance. The only non-adder logic in the sequencer is the index increment.

Decomposition:
- Package cla_seq_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} cla_seq_state_t.
  - Function for the signed-overflow rule.
- Sub-module: one existing cla_adder #(.N(N)) instance, which provides the chunk arithmetic. No new sub-module.
- Chunk select and write-back use indexed part-select [idx*N +: N].

Test Plan:
All cases use N=8 and WORDS=4 (W=32) unless stated otherwise.
1. a=0x000000FF, b=0x00000001, c_in=0, sub=0 -> sum=0x00000100, c_out=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge.
2. a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000, c_out=1, ovf=0 (carry ripples through all 4 chunks).
3. Subtract mode:
   - sub=1, a=5, b=7 -> sum=0xFFFFFFFE, c_out=0, ovf=0.
   - sub=1, a=0x80000000, b=1 -> sum=0x7FFFFFFF, c_out=1, ovf=1.
   - sub=0, a=0x7FFFFFFF, b=1 -> sum=0x80000000, ovf=1.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and changing a and b.
   - out_valid stays 1, sum stays stable, in_ready stays 0.
   - After out_ready=1, the sequencer is in IDLE with in_ready=1 the next cycle; the ignored inputs are never processed.
5. Reset asserted during the 2nd RUN cycle:
   - Next cycle: in_ready=1, out_valid=0, sum=0, c_out=0.
   - A following request a=0x12345678, b=0x11111111 yields 0x23456789.
6. N=2, WORDS=1, and separately N=2, WORDS=4:
   - Exhaustively sweep all a, b and c_in combinations for WORDS=1, plus 200 random operand sets for WORDS=4.
   - Compare {c_out, sum} against the golden a+b+c_in (and a-b), and check ovf against the golden signed result.

Source files
------------

// File: rtl/cla_multiword_sequencer_pkg.sv
// rtl/cla_multiword_sequencer_pkg.sv - shared types and helpers for the multiword CLA sequencer
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_seq_state_t;

  // Operands of equal sign producing a result of the other sign overflow.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_multiword_sequencer_if.sv
// rtl/cla_multiword_sequencer_if.sv - request/result handshake bundle for the multiword CLA sequencer
interface cla_multiword_sequencer_if #(
  parameter int N     = 8,
  parameter int WORDS = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [N*WORDS-1:0]   a;
  logic [N*WORDS-1:0]   b;
  logic                 c_in;
  logic                 sub;
  logic                 out_valid;
  logic                 out_ready;
  logic [N*WORDS-1:0]   sum;
  logic                 c_out;
  logic                 ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/cla_adder.sv
// rtl/cla_adder.sv - N-bit carry-lookahead adder with flat generate/propagate carry terms
module cla_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out
);

  logic [N-1:0] w_g;
  logic [N-1:0] w_p;
  logic [N:0]   w_c;
  logic         w_prod;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Each carry is a sum of products over lower generate bits, never a ripple chain.
  always_comb begin
    w_c    = '0;
    w_prod = 1'b0;
    w_c[0] = c_in;
    for (int i = 0; i < N; i++) begin
      w_c[i+1] = w_g[i];
      w_prod   = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_c[i+1] = w_c[i+1] | (w_prod & w_g[j]);
        w_prod   = w_prod & w_p[j];
      end
      w_c[i+1] = w_c[i+1] | (w_prod & c_in);
    end
  end

  assign s     = w_p ^ w_c[N-1:0];
  assign c_out = w_c[N];

endmodule

// File: rtl/cla_multiword_sequencer.sv
// rtl/cla_multiword_sequencer.sv - wide add/subtract computed one N-bit chunk per cycle on a single CLA
module cla_multiword_sequencer
  import cla_seq_pkg::*;
#(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  cla_multiword_sequencer_if.slave    bus
);

  localparam int            W        = N * WORDS;
  localparam int            IW       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  cla_seq_state_t r_state;
  cla_seq_state_t w_next;

  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic          r_cout;
  logic          r_ovf;

  logic [N-1:0]  w_ca;
  logic [N-1:0]  w_cb;
  logic [N-1:0]  w_s;
  logic          w_co;
  logic          w_accept;
  logic          w_last;

  assign w_ca     = r_a[r_idx*N +: N];
  assign w_cb     = r_b[r_idx*N +: N];
  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_last   = (r_idx == LAST_IDX);

  cla_adder #(.N(N)) u_cla (
    .a     (w_ca),
    .b     (w_cb),
    .c_in  (r_carry),
    .s     (w_s),
    .c_out (w_co)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_next = RUN;
      RUN:     if (w_last)        w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // B is stored pre-inverted for subtract, so RUN never needs to know the mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.sub ? ~bus.b : bus.b;
      r_carry <= bus.sub | bus.c_in;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[r_idx*N +: N] <= w_s;
      r_carry             <= w_co;
      r_idx               <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_co;
        r_ovf  <= signed_ovf(r_a[W-1], r_b[W-1], w_s[N-1]);
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.sum       = r_sum;
  assign bus.c_out     = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// tb/tb_cla_multiword_sequencer.sv - scoreboard bench for the multiword CLA sequencer at three geometries
module tb_cla_multiword_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cla_multiword_sequencer_if #(.N(8), .WORDS(4)) bus8 ();
  cla_multiword_sequencer_if #(.N(2), .WORDS(1)) bus21 ();
  cla_multiword_sequencer_if #(.N(2), .WORDS(4)) bus24 ();

  cla_multiword_sequencer #(.N(8), .WORDS(4)) u_dut8  (.clk(clk), .reset(reset), .bus(bus8));
  cla_multiword_sequencer #(.N(2), .WORDS(1)) u_dut21 (.clk(clk), .reset(reset), .bus(bus21));
  cla_multiword_sequencer #(.N(2), .WORDS(4)) u_dut24 (.clk(clk), .reset(reset), .bus(bus24));

  typedef struct {
    logic [31:0] sum;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t q8[$];
  exp_t q21[$];
  exp_t q24[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference built from signed/unsigned integer arithmetic rather than carry logic.
  function automatic exp_t golden(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic ci, input logic sb);
    longint ua, ub, sa, sbv, r, sr, lim;
    exp_t   e;
    lim = longint'(1) << w;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = a[w-1] ? ua - lim : ua;
    sbv = b[w-1] ? ub - lim : ub;
    if (sb) begin
      r    = ua - ub;
      sr   = sa - sbv;
      e.co = (ua >= ub);
    end else begin
      r    = ua + ub + longint'(ci);
      sr   = sa + sbv + longint'(ci);
      e.co = (r >= lim);
    end
    e.sum = 32'(r & (lim - 1));
    e.ov  = (sr >= lim / 2) || (sr < -(lim / 2));
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (bus8.out_valid && bus8.out_ready) begin
        if (q8.size() == 0) chk("w8_unexpected_result", {31'd0, bus8.out_valid}, 64'd0);
        else begin
          mon_e = q8.pop_front();
          chk("w8_result", {30'd0, bus8.c_out, bus8.ovf, bus8.sum},
              {30'd0, mon_e.co, mon_e.ov, mon_e.sum});
        end
      end
      if (bus21.out_valid && bus21.out_ready) begin
        if (q21.size() == 0) chk("w21_unexpected_result", {31'd0, bus21.out_valid}, 64'd0);
        else begin
          mon_e = q21.pop_front();
          chk("w21_result", {30'd0, bus21.c_out, bus21.ovf, 32'(bus21.sum)},
              {30'd0, mon_e.co, mon_e.ov, mon_e.sum});
        end
      end
      if (bus24.out_valid && bus24.out_ready) begin
        if (q24.size() == 0) chk("w24_unexpected_result", {31'd0, bus24.out_valid}, 64'd0);
        else begin
          mon_e = q24.pop_front();
          chk("w24_result", {30'd0, bus24.c_out, bus24.ovf, 32'(bus24.sum)},
              {30'd0, mon_e.co, mon_e.ov, mon_e.sum});
        end
      end
    end
  end

  task automatic issue8(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb,
                        input logic [31:0] es, input logic eco, input logic eov, input bit push);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!bus8.in_ready && n < 50) begin @(negedge clk); n++; end
    chk("w8_ready_for_issue", {63'd0, bus8.in_ready}, 64'd1);
    e.sum = es; e.co = eco; e.ov = eov;
    if (push) q8.push_back(e);
    bus8.a = a; bus8.b = b; bus8.c_in = ci; bus8.sub = sb; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic issue21(input logic [1:0] a, input logic [1:0] b, input logic ci, input logic sb);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus21.in_ready && n < 50) begin @(negedge clk); n++; end
    chk("w21_ready_for_issue", {63'd0, bus21.in_ready}, 64'd1);
    q21.push_back(golden(2, 32'(a), 32'(b), ci, sb));
    bus21.a = a; bus21.b = b; bus21.c_in = ci; bus21.sub = sb; bus21.in_valid = 1'b1;
    @(posedge clk); #1;
    bus21.in_valid = 1'b0;
  endtask

  task automatic issue24(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus24.in_ready && n < 50) begin @(negedge clk); n++; end
    chk("w24_ready_for_issue", {63'd0, bus24.in_ready}, 64'd1);
    q24.push_back(golden(8, 32'(a), 32'(b), ci, sb));
    bus24.a = a; bus24.b = b; bus24.c_in = ci; bus24.sub = sb; bus24.in_valid = 1'b1;
    @(posedge clk); #1;
    bus24.in_valid = 1'b0;
  endtask

  task automatic wait_idle8();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus8.in_ready && n < 50) begin @(negedge clk); n++; end
    chk("w8_back_to_idle", {63'd0, bus8.in_ready}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    int seen;
    reset = 1'b1;
    bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.c_in  = 1'b0; bus8.sub  = 1'b0;
    bus21.in_valid = 1'b0; bus21.a = '0; bus21.b = '0; bus21.c_in = 1'b0; bus21.sub = 1'b0;
    bus24.in_valid = 1'b0; bus24.a = '0; bus24.b = '0; bus24.c_in = 1'b0; bus24.sub = 1'b0;
    bus8.out_ready = 1'b1; bus21.out_ready = 1'b1; bus24.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("reset_in_ready",  {63'd0, bus8.in_ready},  64'd1);
    chk("reset_out_valid", {63'd0, bus8.out_valid}, 64'd0);
    chk("reset_sum",       {32'd0, bus8.sum},       64'd0);
    chk("reset_c_out",     {63'd0, bus8.c_out},     64'd0);
    chk("reset_ovf",       {63'd0, bus8.ovf},       64'd0);

    issue8(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus8.out_valid && lat < 20);
    chk("w8_latency", 64'(lat), 64'd4);
    wait_idle8();

    issue8(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    issue8(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    issue8(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
    issue8(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    issue8(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b1);
    issue8(32'h0000_0009, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b1);
    wait_idle8();

    bus8.out_ready = 1'b0;
    issue8(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h3333_3333, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!bus8.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus8.in_valid = ~bus8.in_valid;
      bus8.a = $urandom; bus8.b = $urandom; bus8.sub = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("bp_out_valid", {63'd0, bus8.out_valid}, 64'd1);
      chk("bp_sum_stable", {32'd0, bus8.sum}, {32'd0, 32'h3333_3333});
      chk("bp_in_ready", {63'd0, bus8.in_ready}, 64'd0);
    end
    #1;
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", {63'd0, bus8.in_ready}, 64'd1);
    chk("bp_release_out_valid", {63'd0, bus8.out_valid}, 64'd0);
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (bus8.out_valid) seen++; end
    chk("bp_ignored_not_processed", 64'(seen), 64'd0);

    issue8(32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_in_ready", {63'd0, bus8.in_ready}, 64'd1);
    chk("rst_mid_out_valid", {63'd0, bus8.out_valid}, 64'd0);
    chk("rst_mid_sum", {32'd0, bus8.sum}, 64'd0);
    chk("rst_mid_c_out", {63'd0, bus8.c_out}, 64'd0);
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (bus8.out_valid) seen++; end
    chk("rst_mid_discarded", 64'(seen), 64'd0);
    issue8(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b1);
    wait_idle8();

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int ci = 0; ci < 2; ci++)
          for (int sb = 0; sb < 2; sb++)
            issue21(2'(a), 2'(b), 1'(ci), 1'(sb));

    for (int k = 0; k < 200; k++)
      issue24(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    n = 0;
    while ((q8.size() + q21.size() + q24.size()) != 0 && n < 100) begin @(posedge clk); n++; end
    @(negedge clk);
    chk("scoreboard_drained", 64'(q8.size() + q21.size() + q24.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
